// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: widths, FSM states,
// NOP encoding, PC increment and a PC alignment helper.
package fetch_stage_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP    = 16'h0000;
  localparam logic [ADDR_W-1:0]  PC_INC = 16'd2;

  // REQ drives a request, WAIT has one outstanding, HOLD has a response
  // parked in the skid buffer (only reachable with the skid build).
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  // Instructions are 16-bit aligned; bit 0 of any target is ignored.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register that parks a fetched instruction and its address
// while decode is stalled. Occupancy is tracked by the fetch FSM (HOLD).
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  // Capture the response whenever the FSM asks for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP;
      pc    <= '0;
    end else if (load) begin
      instr <= instr_in;
      pc    <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, IF/ID pipeline
// register, redirect handling with stale-response dropping.
// Optional build macro FETCH_SKID_EN adds a one-entry skid buffer so that
// requests may issue while decode is stalled.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready. imem_rsp_valid is a single-cycle
// strobe arriving one or more cycles after the accepting request handshake.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               id_stall,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus2,
  output fetch_state_t       fsm_state
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              stale;
  logic              can_accept;
  logic              can_req;
  logic              req_fire;

  assign can_accept = !id_valid || !id_stall;

`ifdef FETCH_SKID_EN
  // The skid entry absorbs a response that arrives while decode is stalled.
  assign can_req = 1'b1;

  logic               skid_load;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc;

  assign skid_load = (state == ST_WAIT) && imem_rsp_valid && !stale &&
                     !redirect_valid && !can_accept;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .instr_in (imem_rdata),
    .pc_in    (req_pc),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );
`else
  assign can_req = can_accept;
`endif

  // Request is gated by rst_n so nothing is offered while reset is held.
  assign imem_req_valid = rst_n && (state == ST_REQ) && !redirect_valid && can_req;
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign fsm_state      = state;

  // Fetch FSM, PC and IF/ID register; redirect overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      req_pc      <= '0;
      stale       <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc       <= '0;
      id_pc_plus2 <= '0;
    end else if (redirect_valid) begin
      pc       <= align_pc(redirect_pc);
      id_valid <= 1'b0;
      // An outstanding request whose response has not arrived yet must be
      // waited out and then thrown away.
      if (state == ST_WAIT && !imem_rsp_valid) begin
        state <= ST_WAIT;
        stale <= 1'b1;
      end else begin
        state <= ST_REQ;
        stale <= 1'b0;
      end
    end else begin
      if (!id_stall) id_valid <= 1'b0;
      case (state)
        ST_REQ: begin
          if (req_fire) begin
            pc     <= pc + PC_INC;
            req_pc <= pc;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            if (stale) begin
              stale <= 1'b0;
              state <= ST_REQ;
            end else if (can_accept) begin
              id_valid    <= 1'b1;
              id_instr    <= imem_rdata;
              id_pc       <= req_pc;
              id_pc_plus2 <= req_pc + PC_INC;
              state       <= ST_REQ;
            end
`ifdef FETCH_SKID_EN
            else begin
              state <= ST_HOLD;
            end
`endif
          end
        end
`ifdef FETCH_SKID_EN
        ST_HOLD: begin
          if (!id_stall) begin
            id_valid    <= 1'b1;
            id_instr    <= skid_instr;
            id_pc       <= skid_pc;
            id_pc_plus2 <= skid_pc + PC_INC;
            state       <= ST_REQ;
          end
        end
`endif
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a zero-wait memory model that
// returns addr ^ 16'h5A5A one cycle after each accepted request.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [15:0]  imem_addr;
  logic         imem_rsp_valid;
  logic [15:0]  imem_rdata;
  logic         redirect_valid;
  logic [15:0]  redirect_pc;
  logic         id_stall;
  logic         id_valid;
  logic [15:0]  id_instr;
  logic [15:0]  id_pc;
  logic [15:0]  id_pc_plus2;
  fetch_state_t fsm_state;

  int total = 0;
  int bad   = 0;

  logic        rsp_pend;
  logic [15:0] rsp_addr;

  fetch_stage #(.RESET_PC(16'h0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus2    (id_pc_plus2),
    .fsm_state      (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // One clock of the memory model. Called at a falling edge; presents the
  // pending response if allowed, records any handshake, returns at the next
  // falling edge.
  task automatic mem_cycle(input bit respond);
    logic        presented;
    logic        hs;
    logic [15:0] hs_addr;
    presented      = respond && rsp_pend;
    imem_rsp_valid = presented;
    imem_rdata     = presented ? mem_word(rsp_addr) : 16'hDEAD;
    #1;
    hs      = imem_req_valid && imem_req_ready;
    hs_addr = imem_addr;
    @(posedge clk);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    if (presented) rsp_pend = 1'b0;
    if (hs) begin
      rsp_pend = 1'b1;
      rsp_addr = hs_addr;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0; rsp_pend = 1'b0; rsp_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({imem_req_valid, id_valid, id_instr, id_pc, id_pc_plus2} !== 50'd0 || fsm_state !== ST_REQ) begin
      bad++;
      $display("FAIL reset_state: req=%b idv=%b instr=%h pc=%h pc2=%h st=%0d want all zero, st=0",
               imem_req_valid, id_valid, id_instr, id_pc, id_pc_plus2, fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 16'h0100}) begin
      bad++;
      $display("FAIL first_req: valid=%b addr=%h want 1 0100", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a;
      a = 16'h0100 + 16'(2 * i);
      #1;
      total++;
      if ({imem_req_valid, imem_addr} !== {1'b1, a}) begin
        bad++;
        $display("FAIL seq_req%0d: valid=%b addr=%h want 1 %h", i, imem_req_valid, imem_addr, a);
      end
      mem_cycle(1'b1);
      #1;
      total++;
      if ({id_valid, imem_req_valid} !== 2'b00) begin
        bad++;
        $display("FAIL seq_wait%0d: idv=%b req=%b want 0 0", i, id_valid, imem_req_valid);
      end
      mem_cycle(1'b1);
      total++;
      if ({id_valid, id_pc, id_instr, id_pc_plus2} !== {1'b1, a, mem_word(a), a + 16'd2}) begin
        bad++;
        $display("FAIL seq_id%0d: idv=%b pc=%h instr=%h pc2=%h want 1 %h %h %h",
                 i, id_valid, id_pc, id_instr, id_pc_plus2, a, mem_word(a), a + 16'd2);
      end
    end
  endtask

  task automatic test_stall();
    id_stall = 1'b1;
    #1;
`ifndef FETCH_SKID_EN
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL stall_noreq%0d: req=%b want 0", i, imem_req_valid);
      end
      mem_cycle(1'b1);
      #1;
      total++;
      if ({id_valid, id_instr, id_pc} !== {1'b1, 16'h5B5E, 16'h0104}) begin
        bad++;
        $display("FAIL stall_hold%0d: idv=%b instr=%h pc=%h want 1 5b5e 0104", i, id_valid, id_instr, id_pc);
      end
    end
    id_stall = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 16'h0106}) begin
      bad++;
      $display("FAIL stall_resume: valid=%b addr=%h want 1 0106", imem_req_valid, imem_addr);
    end
    mem_cycle(1'b1);
    mem_cycle(1'b1);
`else
    total++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 16'h0106}) begin
      bad++;
      $display("FAIL skid_req: valid=%b addr=%h want 1 0106", imem_req_valid, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      mem_cycle(1'b1);
      #1;
      total++;
      if ({id_valid, id_instr, id_pc} !== {1'b1, 16'h5B5E, 16'h0104}) begin
        bad++;
        $display("FAIL stall_hold%0d: idv=%b instr=%h pc=%h want 1 5b5e 0104", i, id_valid, id_instr, id_pc);
      end
    end
    total++;
    if (fsm_state !== ST_HOLD || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL skid_hold: st=%0d req=%b want 2 0", fsm_state, imem_req_valid);
    end
    id_stall = 1'b0;
    mem_cycle(1'b1);
`endif
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0106, 16'h5B5C} || fsm_state !== ST_REQ) begin
      bad++;
      $display("FAIL stall_release: idv=%b pc=%h instr=%h st=%0d want 1 0106 5b5c 0",
               id_valid, id_pc, id_instr, fsm_state);
    end
  endtask

  task automatic test_redirect_wait();
    mem_cycle(1'b1);
    #1;
    total++;
    if (fsm_state !== ST_WAIT || id_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_pre: st=%0d idv=%b want 1 0", fsm_state, id_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    mem_cycle(1'b0);
    redirect_valid = 1'b0;
    mem_cycle(1'b1);
    #1;
    total++;
    if ({id_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 16'h0040}) begin
      bad++;
      $display("FAIL redir_drop: idv=%b req=%b addr=%h want 0 1 0040", id_valid, imem_req_valid, imem_addr);
    end
    mem_cycle(1'b1);
    total++;
    if (id_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_wait: idv=%b want 0", id_valid);
    end
    mem_cycle(1'b1);
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0040, 16'h5A1A}) begin
      bad++;
      $display("FAIL redir_id: idv=%b pc=%h instr=%h want 1 0040 5a1a", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_redirect_stall();
    id_stall       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    #1;
    total++;
    if (imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL rs_noreq: req=%b want 0", imem_req_valid);
    end
    mem_cycle(1'b1);
    redirect_valid = 1'b0;
    id_stall       = 1'b0;
    #1;
    total++;
    if ({id_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 16'hFFFE}) begin
      bad++;
      $display("FAIL rs_clear: idv=%b req=%b addr=%h want 0 1 fffe", id_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    mem_cycle(1'b1);
    mem_cycle(1'b1);
    #1;
    total++;
    if ({id_valid, id_pc, id_pc_plus2, id_instr} !== {1'b1, 16'hFFFE, 16'h0000, 16'hA5A4}) begin
      bad++;
      $display("FAIL wrap_id: idv=%b pc=%h pc2=%h instr=%h want 1 fffe 0000 a5a4",
               id_valid, id_pc, id_pc_plus2, id_instr);
    end
    total++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_next: req=%b addr=%h want 1 0000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_cycle(1'b1);
    rst_n = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, id_valid, id_instr, id_pc, id_pc_plus2} !== 50'd0 || fsm_state !== ST_REQ) begin
      bad++;
      $display("FAIL rst_async: req=%b idv=%b instr=%h pc=%h pc2=%h st=%0d want all zero",
               imem_req_valid, id_valid, id_instr, id_pc, id_pc_plus2, fsm_state);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n          = 1'b1;
    imem_req_ready = 1'b0;
    #1;
    total++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 16'h0100}) begin
      bad++;
      $display("FAIL rst_restart: req=%b addr=%h want 1 0100", imem_req_valid, imem_addr);
    end
    mem_cycle(1'b1);
    #1;
    total++;
    if (id_valid !== 1'b0 || fsm_state !== ST_REQ) begin
      bad++;
      $display("FAIL rst_late_rsp: idv=%b st=%0d want 0 0", id_valid, fsm_state);
    end
    imem_req_ready = 1'b1;
    mem_cycle(1'b1);
    mem_cycle(1'b1);
    total++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0100, 16'h5B5A}) begin
      bad++;
      $display("FAIL rst_refetch: idv=%b pc=%h instr=%h want 1 0100 5b5a", id_valid, id_pc, id_instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: time=%0t limit=100000", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
